// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU op codes, forwarding selects and multiplier states.
package pipe_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // MEM beats WB; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] addr,
                                         input logic [4:0] a3m, input logic reg_write_m,
                                         input logic [4:0] a3w, input logic reg_write_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (addr != 5'd0 && reg_write_m && addr == a3m) begin
      sel = FWD_M;
    end else if (addr != 5'd0 && reg_write_w && addr == a3w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_stage_serial_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, IDLE -> BUSY -> DONE.
module serial_mul
  import pipe_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int MUL_CYCLES = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_BUSY;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      MUL_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
    if (abort) begin
      state_d = MUL_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // The launch cycle already counts as busy so the pipeline freezes with the operands in place.
  assign busy    = (state_q == MUL_BUSY) || (state_q == MUL_IDLE && start);
  assign done    = (state_q == MUL_DONE);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, serial multiplier hand-off and the EX/MEM register.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int MUL_CYCLES = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_e,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] SignImmE,
  input  logic [4:0]      RD1AddrE,
  input  logic [4:0]      RD2AddrE,
  input  logic [4:0]      A3E,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic            MemWriteE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] ResultW,
  input  logic            RegWriteW,
  input  logic [4:0]      A3W,
  output logic [XLEN-1:0] ALUOutM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      A3M,
  output logic            RegWriteM,
  output logic            MemtoRegM,
  output logic            MemWriteM,
  output logic [2:0]      funct3M,
  output logic            stall_ex
);

  logic [1:0]      fwd_a, fwd_b;
  logic [XLEN-1:0] src_a, src_b, write_data, alu_result, product;
  logic            mul_busy, mul_done;

  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [4:0]      a3_q, a3_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            mem_write_q, mem_write_d;
  logic [2:0]      funct3_q, funct3_d;

  always_comb begin
    fwd_a = fwd_sel(RD1AddrE, a3_q, reg_write_q, A3W, RegWriteW);
    fwd_b = fwd_sel(RD2AddrE, a3_q, reg_write_q, A3W, RegWriteW);
    case (fwd_a)
      FWD_M:   src_a = alu_out_q;
      FWD_W:   src_a = ResultW;
      default: src_a = RD1E;
    endcase
    case (fwd_b)
      FWD_M:   write_data = alu_out_q;
      FWD_W:   write_data = ResultW;
      default: write_data = RD2E;
    endcase
    src_b = ALUSrcE ? SignImmE : write_data;
  end

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a + ~src_b + XLEN'(1);
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_result = src_a << src_b[4:0];
      ALU_MUL: alu_result = mul_done ? product : '0;
      default: alu_result = '0;
    endcase
  end

  serial_mul #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (ALUControlE == ALU_MUL),
    .abort   (flush_e),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  assign stall_ex = rst_n && !flush_e && mul_busy;

  // A killed or frozen instruction must not write anything downstream; its data is left as-is.
  always_comb begin
    alu_out_d    = alu_result;
    write_data_d = write_data;
    a3_d         = A3E;
    reg_write_d  = RegWriteE;
    mem_to_reg_d = MemtoRegE;
    mem_write_d  = MemWriteE;
    funct3_d     = funct3E;
    if (flush_e || stall_ex) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q    <= '0;
      write_data_q <= '0;
      a3_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      funct3_q     <= '0;
    end else begin
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      a3_q         <= a3_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      funct3_q     <= funct3_d;
    end
  end

  assign ALUOutM    = alu_out_q;
  assign WriteDataM = write_data_q;
  assign A3M        = a3_q;
  assign RegWriteM  = reg_write_q;
  assign MemtoRegM  = mem_to_reg_q;
  assign MemWriteM  = mem_write_q;
  assign funct3M    = funct3_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed forwarding/ALU/MUL/flush/reset steps plus a random
// phase, all checked against a latency-level model of the EX/MEM register.
module tb_ex_stage;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_MUL = 3'd7;
  localparam int MUL_STALL = 33;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  ra1, ra2, rd;
    logic [31:0] v1, v2, imm;
    logic        src, rw, mw, mtr;
    logic [2:0]  f3;
  } instr_t;

  logic        clk = 1'b0, rst_n = 1'b0, flush_e;
  logic [31:0] RD1E, RD2E, SignImmE, ResultW;
  logic [4:0]  RD1AddrE, RD2AddrE, A3E, A3W;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegWriteW;
  logic [2:0]  ALUControlE, funct3E;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  A3M;
  logic        RegWriteM, MemtoRegM, MemWriteM, stall_ex;
  logic [2:0]  funct3M;

  int total = 0, bad = 0;

  logic [31:0] m_alu, m_wd, mul_prod;
  logic [4:0]  m_a3;
  logic        m_rw, m_mw, m_mtr, m_valid;
  logic [2:0]  m_f3;
  int          mul_cnt;
  logic        last_obs_stall, last_exp_stall;

  ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_e(flush_e),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RD1AddrE(RD1AddrE), .RD2AddrE(RD2AddrE), .A3E(A3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E),
    .ResultW(ResultW), .RegWriteW(RegWriteW), .A3W(A3W),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .A3M(A3M),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .stall_ex(stall_ex)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [2:0] op, input logic [4:0] ra1, input logic [31:0] v1,
                                input logic [4:0] ra2, input logic [31:0] v2,
                                input logic [31:0] imm, input logic src, input logic [4:0] rd);
    instr_t s;
    s = '{op: op, ra1: ra1, ra2: ra2, rd: rd, v1: v1, v2: v2, imm: imm,
          src: src, rw: 1'b1, mw: 1'b0, mtr: 1'b0, f3: 3'd2};
    return s;
  endfunction

  function automatic instr_t randInstr();
    instr_t s;
    s.op  = 3'($urandom_range(0, 7));
    if (s.op == OP_MUL && $urandom_range(0, 3) != 0) s.op = OP_ADD;
    s.ra1 = 5'($urandom_range(0, 3));
    s.ra2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    s.v1  = $urandom;
    s.v2  = $urandom;
    s.imm = $urandom;
    s.src = 1'($urandom_range(0, 1));
    s.rw  = 1'($urandom_range(0, 1));
    s.mw  = 1'($urandom_range(0, 1));
    s.mtr = 1'($urandom_range(0, 1));
    s.f3  = 3'($urandom_range(0, 7));
    return s;
  endfunction

  // Operand source chosen from the model's own view of MEM and the bench-driven WB stage.
  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] rf);
    if (addr != 5'd0 && m_rw && m_a3 == addr) return m_alu;
    if (addr != 5'd0 && RegWriteW && A3W == addr) return ResultW;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << b[4:0];
      default: return a * b;
    endcase
  endfunction

  task automatic applyStimulus(input instr_t s);
    ALUControlE = s.op;  RD1AddrE = s.ra1; RD2AddrE = s.ra2; A3E = s.rd;
    RD1E = s.v1;  RD2E = s.v2;  SignImmE = s.imm; ALUSrcE = s.src;
    RegWriteE = s.rw; MemWriteE = s.mw; MemtoRegE = s.mtr; funct3E = s.f3;
  endtask

  task automatic setWb(input logic rw, input logic [4:0] a, input logic [31:0] v);
    RegWriteW = rw; A3W = a; ResultW = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkEx();
    checkOutput("RegWriteM", 32'(RegWriteM), 32'(m_rw));
    checkOutput("MemWriteM", 32'(MemWriteM), 32'(m_mw));
    checkOutput("MemtoRegM", 32'(MemtoRegM), 32'(m_mtr));
    if (m_valid) begin
      checkOutput("ALUOutM", ALUOutM, m_alu);
      checkOutput("WriteDataM", WriteDataM, m_wd);
      checkOutput("A3M", 32'(A3M), 32'(m_a3));
      checkOutput("funct3M", 32'(funct3M), 32'(m_f3));
    end
  endtask

  task automatic checkReset(input string tag);
    m_alu = '0; m_wd = '0; m_a3 = '0; m_rw = 1'b0; m_mw = 1'b0; m_mtr = 1'b0;
    m_f3 = '0; m_valid = 1'b1; mul_cnt = 0;
    checkOutput({tag, "_stall"}, 32'(stall_ex), 32'd0);
    checkEx();
  endtask

  // One clock: predict stall and the next EX/MEM contents, then compare both.
  task automatic cycle();
    logic [31:0] sa, sb, wd, res;
    logic        es, starting, rw, mw, mtr, fl;
    logic [4:0]  a3;
    logic [2:0]  f3;
    #1;
    sa = fwd(RD1AddrE, RD1E);
    wd = fwd(RD2AddrE, RD2E);
    sb = ALUSrcE ? SignImmE : wd;
    starting = (mul_cnt == 0) && (ALUControlE == OP_MUL);
    es = rst_n && !flush_e && (starting || (mul_cnt > 0 && mul_cnt < MUL_STALL));
    checkOutput("stall_ex", 32'(stall_ex), 32'(es));
    last_obs_stall = stall_ex;
    last_exp_stall = es;
    if (es && starting) mul_prod = sa * sb;
    res = (mul_cnt == MUL_STALL) ? mul_prod : ref_alu(ALUControlE, sa, sb);
    a3 = A3E; rw = RegWriteE; mw = MemWriteE; mtr = MemtoRegE; f3 = funct3E; fl = flush_e;
    @(posedge clk);
    if (fl || es) begin
      m_rw = 1'b0; m_mw = 1'b0; m_mtr = 1'b0; m_valid = 1'b0;
      mul_cnt = fl ? 0 : mul_cnt + 1;
    end else begin
      m_alu = res; m_wd = wd; m_a3 = a3; m_rw = rw; m_mw = mw; m_mtr = mtr; m_f3 = f3;
      m_valid = 1'b1; mul_cnt = 0;
    end
    #1;
    checkEx();
  endtask

  task automatic runMul(input string tag, input logic [31:0] expv);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!last_obs_stall) break;
      n++;
    end
    checkOutput({tag, "_stall_cycles"}, 32'(n), 32'd33);
    checkOutput({tag, "_result"}, ALUOutM, expv);
    checkOutput({tag, "_regwrite"}, 32'(RegWriteM), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(mk(OP_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0));
    RegWriteE = 1'b0;
    setWb(1'b0, 5'd0, 32'd0);
    flush_e = 1'b0;
    last_obs_stall = 1'b0;
    last_exp_stall = 1'b0;
    mul_prod = '0;
    #7;
    checkReset("reset");
    #1 rst_n = 1'b1;

    // x2 = 3 + 4, then ADD x3,x2,x1 with x2 from MEM and x1 from WB
    applyStimulus(mk(OP_ADD, 5'd0, 32'd3, 5'd0, 32'd0, 32'd4, 1'b1, 5'd2));
    cycle();
    checkOutput("addi_x2", ALUOutM, 32'd7);
    applyStimulus(mk(OP_ADD, 5'd2, 32'd100, 5'd1, 32'd200, 32'd0, 1'b0, 5'd3));
    setWb(1'b1, 5'd1, 32'd5);
    cycle();
    checkOutput("add_chain", ALUOutM, 32'd12);

    // MEM beats WB for x4; x0 is never forwarded
    applyStimulus(mk(OP_ADD, 5'd0, 32'd4, 5'd0, 32'd0, 32'd5, 1'b1, 5'd4));
    setWb(1'b0, 5'd0, 32'd0);
    cycle();
    applyStimulus(mk(OP_ADD, 5'd4, 32'd111, 5'd0, 32'd0, 32'd0, 1'b0, 5'd5));
    setWb(1'b1, 5'd4, 32'd3);
    cycle();
    checkOutput("fwd_priority", ALUOutM, 32'd9);
    applyStimulus(mk(OP_ADD, 5'd0, 32'd50, 5'd0, 32'd0, 32'd5, 1'b1, 5'd0));
    setWb(1'b1, 5'd0, 32'd77);
    cycle();
    applyStimulus(mk(OP_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'd6, 1'b1, 5'd6));
    cycle();
    checkOutput("x0_no_fwd", ALUOutM, 32'd6);

    setWb(1'b0, 5'd0, 32'd0);
    applyStimulus(mk(OP_SLT, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd1, 1'b1, 5'd7));
    cycle();
    checkOutput("slt_signed", ALUOutM, 32'd1);
    applyStimulus(mk(OP_SLL, 5'd0, 32'd1, 5'd0, 32'd0, 32'h21, 1'b1, 5'd8));
    cycle();
    checkOutput("sll_mask", ALUOutM, 32'd2);
    applyStimulus(mk(OP_SUB, 5'd0, 32'd3, 5'd0, 32'd0, 32'd5, 1'b1, 5'd9));
    cycle();
    checkOutput("sub_wrap", ALUOutM, 32'hFFFF_FFFE);

    // Back-to-back MULs, each with full latency
    applyStimulus(mk(OP_MUL, 5'd0, 32'h0001_0003, 5'd0, 32'h0000_0007, 32'd0, 1'b0, 5'd10));
    runMul("mul", 32'h0007_0015);
    applyStimulus(mk(OP_MUL, 5'd0, 32'hFFFF_FFFD, 5'd0, 32'd5, 32'd0, 1'b0, 5'd11));
    runMul("mul_signed", 32'hFFFF_FFF1);

    // Flush at BUSY iteration 10
    applyStimulus(mk(OP_MUL, 5'd0, 32'd123, 5'd0, 32'd456, 32'd0, 1'b0, 5'd12));
    for (int i = 0; i < 11; i++) cycle();
    flush_e = 1'b1;
    cycle();
    checkOutput("flush_stall", 32'(last_obs_stall), 32'd0);
    checkOutput("flush_bubble", 32'(RegWriteM), 32'd0);
    flush_e = 1'b0;
    applyStimulus(mk(OP_ADD, 5'd0, 32'd20, 5'd0, 32'd22, 32'd0, 1'b0, 5'd13));
    cycle();
    checkOutput("post_flush_add", ALUOutM, 32'd42);

    // Async reset in the middle of a MUL, then a fresh MUL
    applyStimulus(mk(OP_MUL, 5'd0, 32'd11, 5'd0, 32'd13, 32'd0, 1'b0, 5'd14));
    for (int i = 0; i < 6; i++) cycle();
    #3 rst_n = 1'b0;
    #1 checkReset("reset_mid_mul");
    #2 rst_n = 1'b1;
    runMul("mul_after_reset", 32'd143);

    // Random traffic; ID/EX stays frozen whenever the model expects a stall
    for (int i = 0; i < 300; i++) begin
      if (!last_exp_stall) applyStimulus(randInstr());
      setWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      flush_e = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush_e = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It consumes the registered ID/EX outputs, resolves operand forwarding from MEM and WB, and computes the ALU result.
- It owns the EX/MEM pipeline register.
- Single-cycle ops complete in one clock. MUL runs on an iterative shift-add unit and holds the pipeline via stall_ex until the product is ready.

Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, shift-add iterations for MUL; must equal XLEN

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- flush_e  in  1  kill instruction in EX (branch/exception); bubble into EX/MEM
- RD1E, RD2E  in  XLEN  register-file operands from ID/EX
- SignImmE  in  XLEN  sign-extended immediate
- RD1AddrE, RD2AddrE  in  5  source register numbers
- A3E  in  5  destination register
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE  in  1  control from ID/EX
- ALUControlE  in  3  ALU op
- funct3E  in  3  load/store size, passed through
- ResultW  in  XLEN  WB-stage writeback value
- RegWriteW  in  1  WB write enable
- A3W  in  5  WB destination
- ALUOutM  out  XLEN  registered ALU/MUL result
- WriteDataM  out  XLEN  registered store data (forwarded RD2)
- A3M  out  5  registered destination
- RegWriteM, MemtoRegM, MemWriteM  out  1  registered control
- funct3M  out  3  registered funct3
- stall_ex  out  1  combinational; hazard unit freezes PC, IF/ID and ID/EX while high

Behaviour:
- Reset: all EX/MEM outputs are 0, multiplier FSM is IDLE, and the counter is 0. stall_ex is 0 under reset.
- ALUControlE encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
  - 101 SLT: signed; result is 1 or 0, zero-extended
  - 110 SLL: shift amount is SrcB[4:0]
  - 111 MUL: low XLEN bits of the product; unsigned and signed results are identical
- Forwarding applies per source (RD1 uses RD1AddrE, RD2 uses RD2AddrE):
  - If the address is non-zero, RegWriteM=1 and A3M matches, take ALUOutM. This is the MEM stage and has highest priority.
  - Otherwise, if the address is non-zero, RegWriteW=1 and A3W matches, take ResultW.
  - Otherwise take the register-file value.
  - Register 0 is never forwarded.
- SrcA is forwarded RD1. SrcB is SignImmE when ALUSrcE=1, otherwise forwarded RD2. WriteData is always forwarded RD2.
- Non-MUL op: result is registered into EX/MEM on the next rising edge, giving 1-cycle latency.
- Multiplier FSM states: IDLE, BUSY, DONE.
  - IDLE with ALUControlE=111 and no flush_e:
    - latch forwarded SrcA and SrcB, clear the accumulator, counter=0
    - go to BUSY; stall_ex=1 this cycle
  - BUSY:
    - each cycle, if multiplier bit 0 is 1, add the multiplicand to the accumulator
    - shift the multiplicand left and the multiplier right; counter increments
    - after counter reaches MUL_CYCLES-1, go to DONE; stall_ex=1 throughout
  - DONE:
    - stall_ex=0; the accumulator is written into EX/MEM with the held MUL control and A3E
    - return to IDLE unconditionally, so a held MUL is never re-triggered
  - Total EX occupancy for MUL is MUL_CYCLES+2 cycles. Back-to-back MULs each take the full latency.
- Operands are captured only in the IDLE→BUSY cycle. Forwarding sources that drain during BUSY are irrelevant.
- Bubble rule: while stall_ex=1, the EX/MEM register loads RegWriteM=0 and MemWriteM=0 (MemtoRegM=0, data don't-care) on each edge.
- flush_e=1 on any edge:
  - EX/MEM loads a bubble
  - FSM forces IDLE and the counter clears
  - stall_ex drops the same cycle, as it is gated by !flush_e
  - flush_e has priority over MUL start and over DONE writeback
- Load-use hazards are not handled here. The hazard unit inserts the bubble, so MEM-stage forwarding of a load address never occurs.
- Arithmetic: all ops are modulo 2^XLEN with no overflow flags. SUB is SrcA + ~SrcB + 1.
- Async reset mid-MUL: the FSM aborts to IDLE and outputs clear immediately.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams for ALU op codes (ALU_ADD..ALU_MUL)
  - forwarding select encoding (FWD_RF=0, FWD_W=1, FWD_M=2)
  - multiplier state encoding
  - XLEN default
- Sub-module serial_mul holds the shift-add FSM and counter.
  - Interface: clk, rst_n, start, abort, a, b, busy, done, product.
- ex_stage holds the forwarding muxes, combinational ALU, stall logic and the EX/MEM register.

Test Plan:
- ADD chain:
  - x1=5 in WB with RegWriteW=1, and an ADD x2 (A3M=2, ALUOutM=7) in MEM
  - EX executes ADD x3,x2,x1
  - expect ALUOutM=12 next cycle (MEM result wins for x2, WB result for x1)
- Priority and x0:
  - A3M=A3W=4 with ALUOutM=9 and ResultW=3 → operand uses 9
  - RD1AddrE=0 with A3M=0, RegWriteM=1 → operand uses RD1E=0, not forwarded
- SLT/SLL:
  - SrcA=0xFFFFFFFF, SrcB=1, SLT → ALUOutM=1
  - SLL of 1 by SrcB=0x21 → 0x00000002
- MUL timing:
  - SrcA=0x0001_0003, SrcB=0x0000_0007, MUL
  - stall_ex high for exactly 33 cycles, then ALUOutM=0x0007_0015 with RegWriteM=1
  - RegWriteM=0 on every stalled edge
  - signed check: -3 × 5 → 0xFFFFFFF1
- Flush mid-MUL: assert flush_e at BUSY iteration 10 → stall_ex=0 that cycle, the next edge leaves RegWriteM=0, and a following ADD completes normally.
- Reset mid-MUL: drop rst_n during BUSY → all outputs read 0 and stall_ex=0 immediately; after release a new MUL takes the full 34 cycles.
